pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 149 ++++++++++++++
 tb/tb_pixel_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Pixel writer: accepts (x, y, colour) pixels, clips off-screen ones, buffers the
// rest as {address, colour} in a small FIFO and drains them to the framebuffer.
module pixel_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic [11:0] color,
  input  logic        in_rts,
  output logic        in_rtr,
  output logic [18:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ack,
  output logic [15:0] clip_cnt,
  output logic        busy
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [18:0] H_MUL = 19'(H_RES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  logic [30:0]  mem_r [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  state_t       state_r;
  state_t       state_nx_s;
  logic [18:0]  fb_addr_r;
  logic [11:0]  fb_data_r;
  logic         fb_we_r;
  logic [15:0]  clip_cnt_r;
  logic         empty_s;
  logic         full_s;
  logic         accept_s;
  logic         clip_s;
  logic         push_s;
  logic         pop_s;
  logic [18:0]  addr_s;
  logic [30:0]  head_s;

  // Full when pointers differ only in the wrap bit, so in_rtr depends on registers alone.
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign accept_s = in_rts && !full_s;
  assign clip_s   = ({1'b0, x_in} >= H_LIM) || ({1'b0, y_in} >= V_LIM);
  assign push_s   = accept_s && !clip_s;
  assign addr_s   = (19'(y_in) * H_MUL) + 19'(x_in);
  assign head_s   = mem_r[rd_ptr_r[AW-1:0]];

  assign in_rtr   = !full_s;
  assign fb_addr  = fb_addr_r;
  assign fb_data  = fb_data_r;
  assign fb_we    = fb_we_r;
  assign clip_cnt = clip_cnt_r;
  assign busy     = !empty_s || fb_we_r;

  // Buffer storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {addr_s, color};
    end
  end

  // FIFO pointers and clipped-pixel counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      clip_cnt_r <= 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      if (accept_s && clip_s && (clip_cnt_r != 16'hFFFF)) begin
        clip_cnt_r <= clip_cnt_r + 16'h0001;
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and pop decision; fb_ack only matters while a write is outstanding.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          state_nx_s = WRITE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WRITE: begin
        if (fb_ack) begin
          if (!empty_s) begin
            pop_s      = 1'b1;
            state_nx_s = WRITE;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = WRITE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Framebuffer request registers, reloaded only when a new entry is popped.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fb_addr_r <= 19'd0;
      fb_data_r <= 12'h000;
      fb_we_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        fb_addr_r <= head_s[30:12];
        fb_data_r <= head_s[11:0];
      end
      fb_we_r <= (state_nx_s == WRITE);
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer: single pixel, clipping,
// backpressure, streaming, corner pixel, counter saturation and mid-run reset.
module tb_pixel_writer;

  logic        clk;
  logic        rst_;
  logic [9:0]  x_in;
  logic [9:0]  y_in;
  logic [11:0] color;
  logic        in_rts;
  logic        in_rtr;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
  logic        fb_ack;
  logic [15:0] clip_cnt;
  logic        busy;

  int checks;
  int failures;

  pixel_writer #(.H_RES(640), .V_RES(480), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .x_in     (x_in),
    .y_in     (y_in),
    .color    (color),
    .in_rts   (in_rts),
    .in_rtr   (in_rtr),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ack   (fb_ack),
    .clip_cnt (clip_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [18:0] stream_addr [5];
    stream_addr[0] = 19'd2560;
    stream_addr[1] = 19'd1920;
    stream_addr[2] = 19'd1280;
    stream_addr[3] = 19'd640;
    stream_addr[4] = 19'd0;
    checks   = 0;
    failures = 0;
    rst_   = 1'b0;
    x_in   = 10'd0;
    y_in   = 10'd0;
    color  = 12'h000;
    in_rts = 1'b0;
    fb_ack = 1'b0;

    // Reset state
    #3;
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_rtr", 32'(in_rtr), 32'd1);
    check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    step();

    // Single pixel (3,2) -> 2*640+3 = 1283
    fb_ack = 1'b1;
    x_in = 10'd3; y_in = 10'd2; color = 12'hF00; in_rts = 1'b1;
    step();
    in_rts = 1'b0;
    check("single_we_latency", 32'(fb_we), 32'd0);
    check("single_busy_queued", 32'(busy), 32'd1);
    step();
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_addr), 32'd1283);
    check("single_data", 32'(fb_data), 32'hF00);
    step();
    check("single_we_done", 32'(fb_we), 32'd0);
    check("single_busy_done", 32'(busy), 32'd0);

    // Clipping: (640,0) and (0,480)
    x_in = 10'd640; y_in = 10'd0; in_rts = 1'b1;
    step();
    check("clip_rtr_a", 32'(in_rtr), 32'd1);
    x_in = 10'd0; y_in = 10'd480;
    step();
    in_rts = 1'b0;
    check("clip_rtr_b", 32'(in_rtr), 32'd1);
    check("clip_cnt_2", 32'(clip_cnt), 32'd2);
    check("clip_busy", 32'(busy), 32'd0);
    step();
    check("clip_no_we", 32'(fb_we), 32'd0);

    // Backpressure: 6 pixels at row 1, ack withheld
    fb_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x_in = 10'(i); y_in = 10'd1; color = 12'(i + 16); in_rts = 1'b1;
      check($sformatf("bp_rtr_%0d", i), 32'(in_rtr), (i < 5) ? 32'd1 : 32'd0);
      step();
    end
    check("bp_rtr_held", 32'(in_rtr), 32'd0);
    check("bp_addr_stable", 32'(fb_addr), 32'd640);
    check("bp_we_held", 32'(fb_we), 32'd1);
    in_rts = 1'b0;
    fb_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_drain_we_%0d", k), 32'(fb_we), 32'd1);
      check($sformatf("bp_drain_addr_%0d", k), 32'(fb_addr), 32'(640 + k));
      check($sformatf("bp_drain_data_%0d", k), 32'(fb_data), 32'(16 + k));
      step();
    end
    check("bp_drain_end_we", 32'(fb_we), 32'd0);
    check("bp_drain_end_busy", 32'(busy), 32'd0);

    // Streaming vertical line (0,4) -> (0,0)
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        x_in = 10'd0; y_in = 10'(4 - i); color = 12'h0F0; in_rts = 1'b1;
        check($sformatf("stream_rtr_%0d", i), 32'(in_rtr), 32'd1);
      end else begin
        in_rts = 1'b0;
      end
      step();
      if (i >= 1) begin
        check($sformatf("stream_we_%0d", i - 1), 32'(fb_we), 32'd1);
        check($sformatf("stream_addr_%0d", i - 1), 32'(fb_addr), 32'(stream_addr[i - 1]));
      end
    end
    step();
    check("stream_end_we", 32'(fb_we), 32'd0);

    // Corner pixel (639,479) -> 479*640+639 = 307199
    x_in = 10'd639; y_in = 10'd479; color = 12'h00F; in_rts = 1'b1;
    step();
    in_rts = 1'b0;
    step();
    check("corner_we", 32'(fb_we), 32'd1);
    check("corner_addr", 32'(fb_addr), 32'd307199);
    check("corner_data", 32'(fb_data), 32'h00F);
    step();

    // Clip counter saturation from a preloaded value
    force dut.clip_cnt_r = 16'hFFFE;
    #1;
    release dut.clip_cnt_r;
    check("sat_preload", 32'(clip_cnt), 32'hFFFE);
    x_in = 10'd700; y_in = 10'd0; in_rts = 1'b1;
    step();
    check("sat_reach", 32'(clip_cnt), 32'hFFFF);
    step();
    check("sat_hold_a", 32'(clip_cnt), 32'hFFFF);
    step();
    in_rts = 1'b0;
    check("sat_hold_b", 32'(clip_cnt), 32'hFFFF);

    // Mid-operation reset with one write pending and 3 buffered
    fb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_in = 10'(10 + i); y_in = 10'd0; in_rts = 1'b1;
      step();
    end
    in_rts = 1'b0;
    check("mr_pre_we", 32'(fb_we), 32'd1);
    check("mr_pre_addr", 32'(fb_addr), 32'd10);
    #2;
    rst_ = 1'b0;
    #1;
    check("mr_we_drop", 32'(fb_we), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_clip_cnt", 32'(clip_cnt), 32'd0);
    check("mr_in_rtr", 32'(in_rtr), 32'd1);
    check("mr_addr", 32'(fb_addr), 32'd0);
    fb_ack = 1'b1;
    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("mr_idle_we_%0d", i), 32'(fb_we), 32'd0);
      check($sformatf("mr_idle_busy_%0d", i), 32'(busy), 32'd0);
    end
    x_in = 10'd1; y_in = 10'd0; color = 12'hABC; in_rts = 1'b1;
    step();
    in_rts = 1'b0;
    step();
    check("mr_after_we", 32'(fb_we), 32'd1);
    check("mr_after_addr", 32'(fb_addr), 32'd1);
    check("mr_after_data", 32'(fb_data), 32'hABC);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
